// File: rtl/nco_pkg.sv
// Shared definitions for the numerically controlled sine oscillator.
// Provides the quadrant encodings, the rounded-sine generator used to fill
// the quarter-wave table at elaboration, and a parameter legality check.
package nco_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam real HALF_PI = 1.5707963267948966;

    // round(amp * sin(pi/2 * k / n4)), ties rounded away from zero
    function automatic int round_sin(input int amp, input int k, input int n4);
        real x;
        x = real'(amp) * $sin(HALF_PI * real'(k) / real'(n4));
        if (x >= 0.0) begin
            return $rtoi($floor(x + 0.5));
        end
        return -$rtoi($floor(-x + 0.5));
    endfunction

    // Table index must fit in the accumulator and the peak must fit signed OUT_W
    function automatic bit params_ok(input int phase_w, input int lut_aw,
                                     input int out_w, input int amp);
        if (lut_aw < 2 || lut_aw > phase_w) return 1'b0;
        if (out_w < 2 || out_w > 31) return 1'b0;
        if (amp < 1 || amp >= (1 << (out_w - 1))) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational full-cycle sine lookup built from a quarter-wave table.
// Ports:
//   idx   in  LUT_AW  phase index, 2^LUT_AW samples per cycle
//   value out OUT_W   signed sine sample for idx
module sine_quarter_rom
    import nco_pkg::*;
#(
    parameter int unsigned LUT_AW = 4,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned AMP    = 64
) (
    input  logic [LUT_AW-1:0]       idx,
    output logic signed [OUT_W-1:0] value
);

    localparam int unsigned N4    = 1 << (LUT_AW - 2);
    localparam int unsigned FW    = LUT_AW - 1;
    localparam int unsigned DEPTH = 1 << FW;

    logic signed [OUT_W-1:0] quarter [DEPTH];
    logic [1:0]              q;
    logic [FW-1:0]           r;
    logic [FW-1:0]           fold;
    logic                    neg;
    logic signed [OUT_W-1:0] mag;

    // Quarter table T[0..N4]; entries past N4 are never addressed
    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        if (k <= N4) begin : g_used
            assign quarter[k] = OUT_W'(round_sin(int'(AMP), k, int'(N4)));
        end else begin : g_pad
            assign quarter[k] = '0;
        end
    end

    assign q = idx[LUT_AW-1 -: 2];

    if (LUT_AW > 2) begin : g_r
        assign r = FW'(idx[LUT_AW-3:0]);
    end else begin : g_r0
        assign r = '0;
    end

    // Odd quadrants read the table backwards, the lower half is negated
    always_comb begin
        fold = r;
        neg  = 1'b0;
        case (q)
            Q0: begin fold = r;             neg = 1'b0; end
            Q1: begin fold = FW'(N4) - r;   neg = 1'b0; end
            Q2: begin fold = r;             neg = 1'b1; end
            Q3: begin fold = FW'(N4) - r;   neg = 1'b1; end
            default: begin fold = r;        neg = 1'b0; end
        endcase
        mag   = quarter[fold];
        value = neg ? -mag : mag;
    end

endmodule

// File: rtl/nco_sine.sv
// Numerically controlled sine oscillator: phase accumulator, phase offset,
// quarter-wave table lookup and a two-stage registered output with attenuation.
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        asynchronous active-high reset
//   en         in  1        advance accumulator and launch one sample
//   sync       in  1        synchronous accumulator clear
//   freq       in  PHASE_W  tuning word added per enabled cycle
//   phase_ofs  in  PHASE_W  phase offset applied before lookup
//   atten      in  3        arithmetic right shift of the sample
//   out        out OUT_W    signed sine sample
//   out_valid  out 1        out carries a new sample this cycle
//   wrap       out 1        accumulator overflowed on the previous edge
module nco_sine
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned LUT_AW  = 4,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned AMP     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sync,
    input  logic [PHASE_W-1:0]      freq,
    input  logic [PHASE_W-1:0]      phase_ofs,
    input  logic [2:0]              atten,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    wrap
);

    if (!params_ok(int'(PHASE_W), int'(LUT_AW), int'(OUT_W), int'(AMP))) begin : g_bad_params
        $error("nco_sine: illegal parameter combination");
    end

    logic [PHASE_W-1:0]      acc;
    logic [PHASE_W:0]        acc_sum;
    logic [PHASE_W-1:0]      phase;
    logic [LUT_AW-1:0]       idx_next;
    logic [LUT_AW-1:0]       idx;
    logic                    v1;
    logic signed [OUT_W-1:0] value;
    logic signed [OUT_W-1:0] scaled;

    // Extra MSB captures the carry-out that drives wrap
    assign acc_sum  = {1'b0, acc} + {1'b0, freq};
    assign phase    = acc + phase_ofs;
    assign idx_next = LUT_AW'(phase >> (PHASE_W - LUT_AW));

    // Phase accumulator; sync wins over en and never reports a wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (sync) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            acc  <= acc_sum[PHASE_W-1:0];
            wrap <= acc_sum[PHASE_W];
        end else begin
            wrap <= 1'b0;
        end
    end

    // Stage 1: table index from the pre-update accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            v1  <= 1'b0;
        end else begin
            idx <= idx_next;
            v1  <= en;
        end
    end

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W),
        .AMP    (AMP)
    ) u_rom (
        .idx   (idx),
        .value (value)
    );

    assign scaled = value >>> atten;

    // Stage 2: attenuated sample; out holds across invalid cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (v1) begin
                out <= scaled;
            end
            out_valid <= v1;
        end
    end

endmodule

// File: tb/tb_nco_sine.sv
// Bench for nco_sine: an ideal-sine reference model checked every cycle plus
// directed sequences compared against hand-computed sample lists.
module tb_nco_sine;

    localparam int PHASE_W = 8;
    localparam int LUT_AW  = 4;
    localparam int OUT_W   = 8;
    localparam int AMP     = 64;

    localparam int SIN0 [16] = '{0, 24, 45, 59, 64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24};
    localparam int COS0 [16] = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};
    localparam int ATT2 [16] = '{0, 6, 11, 14, 16, 14, 11, 6, 0, -6, -12, -15, -16, -15, -12, -6};
    localparam int SYNC [16] = '{0, 24, 45, 59, 64, 59, 0, 24, 45, 0, 0, 0, 0, 0, 0, 0};
    localparam int CONST45 [16] = '{45, 45, 45, 45, 45, 45, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0;
    logic                    sync = 1'b0;
    logic [PHASE_W-1:0]      freq = '0;
    logic [PHASE_W-1:0]      phase_ofs = '0;
    logic [2:0]              atten = '0;
    logic signed [OUT_W-1:0] out;
    logic                    out_valid;
    logic                    wrap;

    nco_sine #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .OUT_W   (OUT_W),
        .AMP     (AMP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .freq      (freq),
        .phase_ofs (phase_ofs),
        .atten     (atten),
        .out       (out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal sample: amplitude-scaled sine of the quantised phase, rounded half away from zero
    function automatic int ideal(input int ph);
        int  i;
        real x;
        i = ph >> (PHASE_W - LUT_AW);
        x = real'(AMP) * $sin(2.0 * 3.14159265358979 * real'(i) / real'(1 << LUT_AW));
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        return -$rtoi($floor(-x + 0.5));
    endfunction

    // Division by 2^a rounded toward minus infinity
    function automatic int attn(input int v, input int a);
        return $rtoi($floor(real'(v) / real'(1 << a)));
    endfunction

    // Reference model: sample chosen at launch, attenuated and shown one edge later
    int m_acc = 0;
    int m_out = 0;
    int m_pval = 0;
    bit m_pv = 1'b0;
    bit m_ov = 1'b0;
    bit m_wrap = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc  <= 0;
            m_out  <= 0;
            m_pval <= 0;
            m_pv   <= 1'b0;
            m_ov   <= 1'b0;
            m_wrap <= 1'b0;
        end else begin
            if (m_pv) m_out <= attn(m_pval, int'(atten));
            m_ov   <= m_pv;
            m_pv   <= en;
            m_pval <= ideal((m_acc + int'(phase_ofs)) % (1 << PHASE_W));
            if (sync) begin
                m_acc  <= 0;
                m_wrap <= 1'b0;
            end else if (en) begin
                m_acc  <= (m_acc + int'(freq)) % (1 << PHASE_W);
                m_wrap <= (m_acc + int'(freq)) >= (1 << PHASE_W);
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    // Per-cycle compare and sample collection
    bit mon = 1'b0;
    bit collect = 1'b0;
    int got[$];
    int wrap_cnt = 0;
    int ov_cnt = 0;

    always @(negedge clk) begin
        if (mon) begin
            check("out", int'(out), m_out);
            check("out_valid", int'(out_valid), int'(m_ov));
            check("wrap", int'(wrap), int'(m_wrap));
            if (collect) begin
                if (out_valid) begin
                    got.push_back(int'(out));
                    ov_cnt++;
                end
                if (wrap) wrap_cnt++;
            end
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_collect();
        got.delete();
        wrap_cnt = 0;
        ov_cnt   = 0;
        collect  = 1'b1;
    endtask

    task automatic wait_samples(input string name, input int n);
        for (int c = 0; c < 400 && got.size() < n; c++) @(negedge clk);
        if (got.size() < n) check({name, "_timeout"}, got.size(), n);
    endtask

    task automatic check_seq(input string name, input int exp[16], input int off, input int n);
        for (int i = 0; i < n; i++) begin
            if (off + i < got.size())
                check($sformatf("%s[%0d]", name, off + i), got[off + i], exp[i]);
            else
                check($sformatf("%s[%0d]_missing", name, off + i), -999, exp[i]);
        end
    endtask

    initial begin
        // Pin the reference model to hand-computed values
        check("model_ideal_q1", ideal(64), 64);
        check("model_ideal_32", ideal(32), 45);
        check("model_ideal_208", ideal(208), -59);
        check("model_attn_neg", attn(-45, 2), -12);

        // Reset state
        @(negedge clk);
        mon = 1'b1;
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_wrap", int'(wrap), 0);
        rst = 1'b0;

        // Basic sine, two full cycles, one wrap per cycle
        freq = 8'd16;
        en   = 1'b1;
        start_collect();
        wait_samples("sine", 32);
        check_seq("sine", SIN0, 0, 16);
        check_seq("sine", SIN0, 16, 16);
        check("sine_wraps", wrap_cnt, 2);
        collect = 1'b0;

        // Quarter-turn offset gives cosine
        do_reset();
        phase_ofs = 8'd64;
        en = 1'b1;
        start_collect();
        wait_samples("cos", 8);
        check_seq("cos", COS0, 0, 8);
        collect = 1'b0;
        phase_ofs = 8'd0;

        // Attenuation by 4, floor rounding on the negative half
        do_reset();
        atten = 3'd2;
        en = 1'b1;
        start_collect();
        wait_samples("att2", 16);
        check_seq("att2", ATT2, 0, 16);
        collect = 1'b0;
        atten = 3'd0;

        // Gapped enable: one valid per enabled cycle, sequence unbroken
        do_reset();
        start_collect();
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("gap_valid_count", ov_cnt, 4);
        check_seq("gap", SIN0, 0, 4);
        collect = 1'b0;

        // Sync after five launches: in-flight sample kept, then restart at 0
        do_reset();
        en = 1'b1;
        start_collect();
        repeat (5) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        wait_samples("sync", 9);
        check_seq("sync", SYNC, 0, 9);
        check("sync_no_wrap", wrap_cnt, 0);
        collect = 1'b0;

        // Zero tuning word: constant output, always valid, no wrap
        do_reset();
        freq = 8'd0;
        phase_ofs = 8'd32;
        en = 1'b1;
        start_collect();
        wait_samples("const", 6);
        check_seq("const", CONST45, 0, 6);
        check("const_no_wrap", wrap_cnt, 0);
        collect = 1'b0;
        phase_ofs = 8'd0;
        freq = 8'd16;

        // Asynchronous reset between edges, then restart
        do_reset();
        en = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_arst_out", int'(out), 64);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out", int'(out), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_wrap", int'(wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        start_collect();
        @(negedge clk);
        check("arst_first_edge_valid", int'(out_valid), 0);
        @(negedge clk);
        check("arst_second_edge_valid", int'(out_valid), 1);
        check("arst_second_edge_out", int'(out), 0);
        wait_samples("arst", 4);
        check_seq("arst", SIN0, 0, 4);
        collect = 1'b0;

        mon = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nco_sine.md
# nco_sine

Parametrised numerically controlled sine oscillator: a phase accumulator drives a quarter-wave sine table, with phase offset, amplitude attenuation and a registered two-stage output pipeline. It replaces the fixed 16-entry, 8-bit full-cycle sine table used by the waveform path. It feeds the DAC/PWM stage and any block that needs a signed sine sample stream at a programmable frequency.

## Interface
- PHASE_W, 8: phase accumulator width.
- LUT_AW, 4: number of phase MSBs used as table index (2^LUT_AW samples per cycle); must be ≥ 2 and ≤ PHASE_W.
- OUT_W, 8: signed output width.
- AMP, 64: peak amplitude; must be < 2^(OUT_W-1).

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance accumulator and launch one sample into the pipeline.
- sync  in  1  synchronous phase clear of the accumulator.
- freq  in  PHASE_W  tuning word, unsigned, added per enabled cycle.
- phase_ofs  in  PHASE_W  phase offset added before table lookup.
- atten  in  3  arithmetic right-shift applied to the table value (0 = full scale).
- out  out  OUT_W  signed two's-complement sine sample.
- out_valid  out  1  out holds a new sample this cycle.
- wrap  out  1  one-cycle pulse: accumulator overflowed on the previous edge.

## Operation
- Accumulator acc (PHASE_W): sync=1 → acc←0 (regardless of en), wrap←0. Else en=1 → acc←(acc+freq) mod 2^PHASE_W, wrap←carry-out. Else acc holds, wrap←0.
- Stage 1: idx←top LUT_AW bits of (acc+phase_ofs) mod 2^PHASE_W, using the current (pre-update) acc; v1←en.
- Quarter table T[k], k=0..N4 with N4=2^(LUT_AW-2): T[k]=round(AMP·sin(π/2·k/N4)), round half away from zero, computed at elaboration. Defaults give T = 0,24,45,59,64.
- Quadrant q=idx[LUT_AW-1:LUT_AW-2], r=idx[LUT_AW-3:0] (r=0 if LUT_AW=2): q0 → T[r]; q1 → T[N4-r]; q2 → −T[r]; q3 → −T[N4-r]. Negative half is exact two's-complement negation (symmetric waveform).
- Stage 2: when v1=1, out←value >>> atten (arithmetic, floor toward −∞), sign-extended to OUT_W; out_valid←v1. When v1=0, out holds last value, out_valid←0.
- freq, phase_ofs and atten changes take effect on the next edge that samples them; no glitch filtering.

## Timing
- Reset values: acc=0, idx=0, v1=0, out=0, out_valid=0, wrap=0. Assertion takes effect immediately; reset mid-stream discards in-flight samples.
- Latency: acc value present in cycle t appears on out in cycle t+2 if en=1 in cycle t.
- First valid sample after reset with en held high: out=T-derived value for phase 0+phase_ofs, out_valid=1 after the second rising edge.
- Throughput: one sample per clock with en=1; en gaps produce out_valid gaps, no sample loss or duplication.
- sync and en in same cycle: stage 1 samples old acc (sample still emitted), acc←0; next sample is phase 0.
- freq=0 with en=1: constant output, out_valid=1 every cycle, wrap never asserts.
- wrap asserts in the cycle after the overflowing edge, exactly once per overflow.

## Structure
- Package nco_pkg: quadrant encoding localparams (Q0..Q3), rounded-sine constant function used for table generation, parameter legality checks.
- Sub-module sine_quarter_rom: combinational, parameters LUT_AW/OUT_W/AMP, input idx, output signed full-cycle value (quadrant folding and negation inside). Top holds accumulator, pipeline registers and attenuation.

## Test plan
- Defaults, freq=16, phase_ofs=0, atten=0, en=1: out = 0,24,45,59,64,59,45,24,0,−24,−45,−59,−64,−59,−45,−24 repeating; wrap pulses every 16 cycles.
- phase_ofs=64: first valid out=64 (cosine), sequence 64,59,45,24,0,−24,...
- atten=2, freq=16: out = 0,6,11,14,16,14,11,6,0,−6,−12,−15,−16,−15,−12,−6.
- en toggled 1,0,1,0 with freq=16: out_valid follows en delayed 2 cycles; out holds between valids; sequence unbroken 0,24,45,...
- sync asserted mid-stream (after 5 samples): sample in flight still emitted, then sequence restarts at 0; wrap not asserted on sync.
- rst asserted asynchronously between edges mid-stream: out, out_valid, wrap go to 0 immediately; after release, stream restarts at 0 on the second enabled edge.
